// File: rtl/ctrlword_uart_tx.sv
// Serializes a captured 20-bit control word as 5 uppercase hex digits + CR (+ LF) over 8N1 UART.
// Returns a one-cycle tx_finish pulse when the last stop bit completes.
module ctrlword_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter bit          APPEND_LF    = 1'b1
) (
    input  logic        clk_core,
    input  logic        rstn,
    input  logic        data_en,
    input  logic [19:0] controlword_hex,
    output logic        sout,
    output logic        busy,
    output logic        tx_finish,
    output logic        frame_drop
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_IDX  = APPEND_LF ? 3'd6 : 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [19:0]       r_word;
    logic [7:0]        r_shift;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [2:0]        r_idx;
    logic              r_data_en_d;

    logic              w_rise;
    logic [2:0]        w_next_idx;
    logic [7:0]        w_next_char;
    logic [7:0]        w_first_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] char_at(input logic [19:0] w, input logic [2:0] idx);
        case (idx)
            3'd0:    return hex_ascii(w[19:16]);
            3'd1:    return hex_ascii(w[15:12]);
            3'd2:    return hex_ascii(w[11:8]);
            3'd3:    return hex_ascii(w[7:4]);
            3'd4:    return hex_ascii(w[3:0]);
            3'd5:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign w_rise       = data_en & ~r_data_en_d;
    assign w_next_idx   = r_idx + 3'd1;
    assign w_next_char  = char_at(r_word, w_next_idx);
    assign w_first_char = char_at(controlword_hex, 3'd0);

    always_ff @(posedge clk_core) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_shift     <= '0;
            r_baud      <= '0;
            r_bit       <= '0;
            r_idx       <= '0;
            r_data_en_d <= 1'b0;
            sout        <= 1'b1;
            busy        <= 1'b0;
            tx_finish   <= 1'b0;
            frame_drop  <= 1'b0;
        end else begin
            r_data_en_d <= data_en;
            tx_finish   <= 1'b0;
            frame_drop  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_word  <= controlword_hex;
                        r_idx   <= '0;
                        r_shift <= w_first_char;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        sout    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        sout    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            sout    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            sout    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                // The "next character" step is folded into the end of the stop bit so no idle gap appears.
                S_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_idx == LAST_IDX) begin
                            busy      <= 1'b0;
                            tx_finish <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_shift <= w_next_char;
                            sout    <= 1'b0;
                            r_state <= S_START;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Any edge outside IDLE (including the DONE cycle) is rejected.
            if (w_rise && (r_state != S_IDLE)) begin
                frame_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrlword_uart_tx.sv
// Scoreboard bench for ctrlword_uart_tx: expected ASCII characters are queued at stimulus time
// and popped as a sout decoder reassembles each 8N1 character.
module tb_ctrlword_uart_tx;

    localparam int unsigned K = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        data_en_a;
    logic        data_en_b;
    logic [19:0] cw;
    logic        sout_a, busy_a, fin_a, drop_a;
    logic        sout_b, busy_b, fin_b, drop_b;
    logic        sel;
    logic        m_sout, m_busy, m_fin, m_drop;

    always #5 clk = ~clk;

    ctrlword_uart_tx #(.CLKS_PER_BIT(K), .APPEND_LF(1'b1)) dut_a (
        .clk_core(clk), .rstn(rstn), .data_en(data_en_a), .controlword_hex(cw),
        .sout(sout_a), .busy(busy_a), .tx_finish(fin_a), .frame_drop(drop_a)
    );

    ctrlword_uart_tx #(.CLKS_PER_BIT(K), .APPEND_LF(1'b0)) dut_b (
        .clk_core(clk), .rstn(rstn), .data_en(data_en_b), .controlword_hex(cw),
        .sout(sout_b), .busy(busy_b), .tx_finish(fin_b), .frame_drop(drop_b)
    );

    assign m_sout = sel ? sout_b : sout_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_fin  = sel ? fin_b  : fin_a;
    assign m_drop = sel ? drop_b : drop_a;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb[$];
    int         fin_cnt  = 0;
    int         drop_cnt = 0;
    int         f0, d0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        if (n < 4'd10) return 8'd48 + {4'h0, n};
        else           return 8'd65 + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_word(input logic [19:0] w, input bit lf);
        for (int i = 4; i >= 0; i--) sb.push_back(asc(w[i*4 +: 4]));
        sb.push_back(8'h0D);
        if (lf) sb.push_back(8'h0A);
    endtask

    task automatic kick(input logic [19:0] w, input bit use_b);
        @(posedge clk);
        #1;
        sel = use_b;
        cw  = w;
        push_word(w, !use_b);
        if (use_b) data_en_b = 1'b1;
        else       data_en_a = 1'b1;
    endtask

    // Called right after kick(): checks start latency, frame length, busy span and pulse width.
    task automatic frame_check(input bit pulse, input int chars);
        int n;
        int bcnt;
        bit got;
        @(negedge clk);
        chk("pre_sout", 32'(m_sout), 1);
        chk("pre_busy", 32'(m_busy), 0);
        @(posedge clk);
        #1;
        cw = ~cw;
        if (pulse) begin
            data_en_a = 1'b0;
            data_en_b = 1'b0;
        end
        @(negedge clk);
        chk("start_sout", 32'(m_sout), 0);
        chk("start_busy", 32'(m_busy), 1);
        n    = 0;
        bcnt = 1;
        got  = 1'b0;
        while (!got && n < 4000) begin
            @(negedge clk);
            n++;
            if (m_fin) got = 1'b1;
            if (m_busy) bcnt++;
        end
        chk("fin_latency", 32'(n), 32'(chars * 10 * K));
        chk("busy_len", 32'(bcnt), 32'(chars * 10 * K));
        chk("busy_at_fin", 32'(m_busy), 0);
        chk("sb_left", 32'(sb.size()), 0);
        @(negedge clk);
        chk("fin_width", 32'(m_fin), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (fin_a)  fin_cnt++;
            if (fin_b)  fin_cnt++;
            if (drop_a) drop_cnt++;
            if (drop_b) drop_cnt++;
        end
    end

    logic       samp[0:10*K-1];
    bit         mact = 1'b0;
    int         mpos = 0;
    int         glitch;
    logic [7:0] ch, exp_ch;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mact = 1'b0;
            end else if (!mact) begin
                if (m_sout == 1'b0) begin
                    mact    = 1'b1;
                    mpos    = 0;
                    samp[0] = 1'b0;
                end
            end else begin
                mpos++;
                samp[mpos] = m_sout;
                if (mpos == 10 * K - 1) begin
                    mact   = 1'b0;
                    glitch = 0;
                    for (int b = 0; b < 10; b++)
                        for (int j = 1; j < K; j++)
                            if (samp[b*K + j] !== samp[b*K]) glitch++;
                    for (int b = 0; b < 8; b++) ch[b] = samp[(b + 1) * K];
                    chk("bit_width", 32'(glitch), 0);
                    chk("stop_bit", 32'(samp[9*K]), 1);
                    chk("sb_pending", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp_ch = sb.pop_front();
                        chk("char", 32'(ch), 32'(exp_ch));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn      = 1'b0;
        data_en_a = 1'b0;
        data_en_b = 1'b0;
        cw        = '0;
        sel       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sout", 32'(sout_a), 1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_fin", 32'(fin_a), 0);
        chk("rst_drop", 32'(drop_a), 0);
        chk("rst_sout_b", 32'(sout_b), 1);
        chk("rst_busy_b", 32'(busy_b), 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);

        // Basic frame with mixed digits and letters
        f0 = fin_cnt;
        kick(20'h1A2F3, 1'b0);
        frame_check(1'b1, 7);
        chk("t1_fin_count", 32'(fin_cnt - f0), 1);

        kick(20'h00000, 1'b0);
        frame_check(1'b1, 7);
        kick(20'hFFFFF, 1'b0);
        frame_check(1'b1, 7);

        // Level held high: a single frame only
        repeat (3) @(posedge clk);
        f0 = fin_cnt;
        d0 = drop_cnt;
        kick(20'h0BEEF, 1'b0);
        frame_check(1'b0, 7);
        repeat (1000 - 283) @(posedge clk);
        #1 data_en_a = 1'b0;
        repeat (20) @(posedge clk);
        chk("hold_fin", 32'(fin_cnt - f0), 1);
        chk("hold_drop", 32'(drop_cnt - d0), 0);

        // Second edge mid-frame is dropped
        f0 = fin_cnt;
        d0 = drop_cnt;
        kick(20'h5C0DE, 1'b0);
        fork
            frame_check(1'b1, 7);
            begin
                repeat (51) @(posedge clk);
                #1;
                cw        = 20'h77777;
                data_en_a = 1'b1;
                @(negedge clk);
                chk("drop_early", 32'(m_drop), 0);
                @(posedge clk);
                #1 data_en_a = 1'b0;
                @(negedge clk);
                chk("drop_pulse", 32'(m_drop), 1);
                @(negedge clk);
                chk("drop_width", 32'(m_drop), 0);
            end
        join
        repeat (400) @(posedge clk);
        chk("drop_fin", 32'(fin_cnt - f0), 1);
        chk("drop_count", 32'(drop_cnt - d0), 1);
        chk("drop_sb", 32'(sb.size()), 0);
        chk("drop_idle", 32'(busy_a), 0);

        // Reset in the middle of a frame
        f0 = fin_cnt;
        kick(20'hABCDE, 1'b0);
        @(posedge clk);
        #1 data_en_a = 1'b0;
        repeat (99) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_sout", 32'(sout_a), 1);
        chk("abort_busy", 32'(busy_a), 0);
        repeat (400) @(posedge clk);
        chk("abort_nofin", 32'(fin_cnt - f0), 0);
        kick(20'h13579, 1'b0);
        frame_check(1'b1, 7);

        // CR-only variant
        repeat (3) @(posedge clk);
        kick(20'h12345, 1'b1);
        frame_check(1'b1, 6);
        repeat (10) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
